shift_seq_ctrl: RTL and testbench



---
 rtl/shift_seq_ctrl.sv | 112 +++++++++++
 tb/tb_shift_seq_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - multi-pass sequencer around the combinational barrel_shift core
// Optional sticky (shifted-out bits) output enabled by SHIFT_STICKY_EN.
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_dir,
    input  logic [AMT_W-1:0] req_amt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [WIDTH-1:0] sh_in,
    output logic             sh_dir,
    output logic [SHW-1:0]   sh_shamt,
    input  logic [WIDTH-1:0] sh_out
`ifdef SHIFT_STICKY_EN
    ,
    output logic             res_sticky
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [AMT_W-1:0] MAXS = AMT_W'((1 << SHW) - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] data_reg, data_n;
    logic             dir_reg, dir_n;
    logic [AMT_W-1:0] rem, rem_n;
    logic [AMT_W-1:0] step;

    // Each pass takes as much of the remaining amount as the core can do at once.
    assign step      = (rem > MAXS) ? MAXS : rem;
    assign sh_in     = data_reg;
    assign sh_dir    = dir_reg;
    assign sh_shamt  = (state == BUSY) ? step[SHW-1:0] : '0;
    assign req_ready = (state == IDLE) && rst_n;
    assign res_valid = (state == DONE);
    assign res_data  = data_reg;

`ifdef SHIFT_STICKY_EN
    localparam logic [WIDTH-1:0] ONES = '1;
    logic             sticky, sticky_n;
    logic [WIDTH-1:0] lost;

    // Bits falling off the end of this pass: top bits for left, bottom bits for right.
    assign lost       = dir_reg ? (data_reg & ~(ONES >> step)) : (data_reg & ~(ONES << step));
    assign res_sticky = sticky;
`endif

    always_comb begin
        state_n  = state;
        data_n   = data_reg;
        dir_n    = dir_reg;
        rem_n    = rem;
`ifdef SHIFT_STICKY_EN
        sticky_n = sticky;
`endif
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    data_n   = req_data;
                    dir_n    = req_dir;
                    rem_n    = req_amt;
`ifdef SHIFT_STICKY_EN
                    sticky_n = 1'b0;
`endif
                    state_n  = (req_amt != '0) ? BUSY : DONE;
                end
            end
            BUSY: begin
                data_n   = sh_out;
                rem_n    = rem - step;
`ifdef SHIFT_STICKY_EN
                sticky_n = sticky | (|lost);
`endif
                if (rem == step) state_n = DONE;
            end
            DONE: begin
                if (res_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_reg <= '0;
            dir_reg  <= 1'b0;
            rem      <= '0;
`ifdef SHIFT_STICKY_EN
            sticky   <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            data_reg <= data_n;
            dir_reg  <= dir_n;
            rem      <= rem_n;
`ifdef SHIFT_STICKY_EN
            sticky   <= sticky_n;
`endif
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl with a barrel_shift model
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_data = 8'h00;
    logic       req_dir = 1'b0;
    logic [3:0] req_amt = 4'd0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic [7:0] sh_in;
    logic       sh_dir;
    logic [2:0] sh_shamt;
    logic [7:0] sh_out;
`ifdef SHIFT_STICKY_EN
    logic       res_sticky;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       dir;
        logic [3:0] amt;
        logic [7:0] exp;
        int         hold;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       sticky;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    always #5 clk = ~clk;

    // Combinational barrel_shift core model
    assign sh_out = sh_dir ? (sh_in << sh_shamt) : (sh_in >> sh_shamt);

    shift_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_dir(req_dir), .req_amt(req_amt),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .sh_in(sh_in), .sh_dir(sh_dir), .sh_shamt(sh_shamt), .sh_out(sh_out)
`ifdef SHIFT_STICKY_EN
        , .res_sticky(res_sticky)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ref_sticky(input logic [7:0] d, input logic dir, input logic [3:0] amt);
        logic [15:0] w;
        w = {8'h00, d};
        if (amt == 0) return 1'b0;
        if (amt >= 8) return d != 0;
        if (dir) return ((w << amt) >> 8) != 0;
        return (w & ((16'd1 << amt) - 16'd1)) != 0;
    endfunction

    task automatic run_req(input logic [7:0] d, input logic dir, input logic [3:0] amt,
                           input logic [7:0] exp, input int hold);
        int   lat;
        int   npass;
        int   sum;
        exp_t e;
        lat = 0; npass = 0; sum = 0;
        @(posedge clk); #1;
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_data = d; req_dir = dir; req_amt = amt;
        sb.push_back('{data: exp, sticky: ref_sticky(d, dir, amt)});
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) req_valid = 1'b0;
            if (sh_shamt != 0) begin
                npass++;
                sum += int'(sh_shamt);
            end
            if (res_valid || lat >= 40) break;
        end
        if (!res_valid) begin
            check("res_valid_timeout", 0, 1);
            void'(sb.pop_front());
            return;
        end
        check("latency", lat, (int'(amt) + 6) / 7 + 1);
        check("passes", npass, (int'(amt) + 6) / 7);
        check("shamt_sum", sum, int'(amt));
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                req_valid = 1'b1; req_data = 8'hA5; req_dir = ~dir; req_amt = 4'd3;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
            check("bp_valid", res_valid, 1);
            check("bp_data", res_data, exp);
            check("bp_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        e = sb.pop_front();
        check("res_data", res_data, e.data);
`ifdef SHIFT_STICKY_EN
        check("res_sticky", res_sticky, e.sticky);
`endif
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("res_valid_drop", res_valid, 0);
        check("req_ready_back", req_ready, 1);
    endtask

    initial begin
        vecs[0] = '{8'h00, 1'b1, 4'd0,  8'h00, 0};
        vecs[1] = '{8'h80, 1'b0, 4'd4,  8'h08, 0};
        vecs[2] = '{8'h80, 1'b0, 4'd2,  8'h20, 0};
        vecs[3] = '{8'h80, 1'b1, 4'd1,  8'h00, 0};
        vecs[4] = '{8'hFF, 1'b1, 4'd7,  8'h80, 0};
        vecs[5] = '{8'hFF, 1'b0, 4'd9,  8'h00, 0};
        vecs[6] = '{8'h81, 1'b0, 4'd1,  8'h40, 5};
        vecs[7] = '{8'h3C, 1'b1, 4'd15, 8'h00, 0};
        vecs[8] = '{8'h3C, 1'b1, 4'd2,  8'hF0, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_sh_in", sh_in, 0);
        check("rst_sh_dir", sh_dir, 0);
        check("rst_sh_shamt", sh_shamt, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_req(vecs[i].data, vecs[i].dir, vecs[i].amt, vecs[i].exp, vecs[i].hold);

        // Abort during the second pass of a 15-step shift
        @(posedge clk); #1;
        req_valid = 1'b1; req_data = 8'hFF; req_dir = 1'b1; req_amt = 4'd15;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_pass1", sh_shamt, 7);
        @(posedge clk); #1;
        check("abort_pass2", sh_shamt, 7);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_res_valid", res_valid, 0);
        check("abort_res_data", res_data, 0);
        check("abort_sh_in", sh_in, 0);
        check("abort_sh_dir", sh_dir, 0);
        check("abort_sh_shamt", sh_shamt, 0);
        check("abort_req_ready", req_ready, 0);
        rst_n = 1'b1;
        #1;
        check("abort_idle", req_ready, 1);

        run_req(8'h01, 1'b1, 4'd8, 8'h00, 0);
        run_req(8'hC3, 1'b0, 4'd3, 8'h18, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
